// File: rtl/bocks_pkg.sv
// Shared definitions for the bocks_top memory paths.
// Holds the upload reader state type, the default SDRAM word-address width
// (shared with the ioctl download path) and a byte-lane select helper.
package bocks_pkg;

  // SDRAM word-address width (16-bit words).
  localparam int unsigned SDRAM_ADDR_W = 25;

  // Width of the hps_io byte address and of the served-byte counter.
  localparam int unsigned IOCTL_ADDR_W = 27;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } upload_state_t;

  // Even byte addresses live in the low lane of a word.
  function automatic logic [7:0] select_byte(input logic [15:0] word, input logic sel);
    return sel ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/ioctl_word_buf.sv
// One-word read buffer for the ioctl upload path.
// Ports:
//   clk_sys, reset  - system clock, synchronous active-high reset
//   clear           - invalidate the buffer
//   load            - capture load_word under tag load_tag and mark valid
//   lookup_tag/sel  - word address and byte lane of the current host read
//   hit             - buffer is valid and holds lookup_tag
//   rd_byte         - selected byte of the buffered word
module ioctl_word_buf
  import bocks_pkg::*;
#(
  parameter int unsigned ADDR_W = SDRAM_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [15:0]       load_word,
  input  logic [ADDR_W-1:0] load_tag,
  input  logic [ADDR_W-1:0] lookup_tag,
  input  logic              lookup_sel,
  output logic              hit,
  output logic [7:0]        rd_byte
);

  logic [15:0]       word_q;
  logic [ADDR_W-1:0] tag_q;
  logic              valid_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      word_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= load_word;
      tag_q   <= load_tag;
      valid_q <= 1'b1;
    end
  end

  always_comb begin
    hit     = valid_q && (tag_q == lookup_tag);
    rd_byte = select_byte(word_q, lookup_sel);
  end

endmodule

// File: rtl/ioctl_upload_reader.sv
// Upload-direction reader for the ioctl channel: serves hps_io byte reads from
// SDRAM through the arbiter's secondary request port, keeping one buffered
// word and prefetching the next word after an odd-byte hit.
// Ports:
//   clk_sys, reset         - system clock, synchronous active-high reset
//   ioctl_upload           - upload session active
//   ioctl_rd, ioctl_addr   - one-cycle byte read strobe and byte address
//   ioctl_din, ioctl_wait  - returned byte and stall (high until din valid)
//   mem_rd, mem_addr       - word read request, held until mem_ack
//   mem_ack, mem_dout      - acknowledge with read word in the same cycle
//   bytes_served           - saturating count of completed reads this session
module ioctl_upload_reader
  import bocks_pkg::*;
#(
  parameter int unsigned ADDR_W    = SDRAM_ADDR_W,
  parameter int unsigned BASE_WORD = 0
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ioctl_upload,
  input  logic                    ioctl_rd,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  output logic [7:0]              ioctl_din,
  output logic                    ioctl_wait,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [15:0]             mem_dout,
  output logic [IOCTL_ADDR_W-1:0] bytes_served
);

  upload_state_t state_q, state_d;

  logic                    upload_q;
  logic                    pend_q, pend_d;
  logic                    pend_sel_q, pend_sel_d;
  logic [ADDR_W-1:0]       drain_addr_q, drain_addr_d;
  logic                    drain_pend_q, drain_pend_d;
  logic                    drain_sel_q, drain_sel_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [7:0]              din_q, din_d;
  logic                    wait_q, wait_d;
  logic [IOCTL_ADDR_W-1:0] bytes_q, bytes_d;

  logic              serve;
  logic              buf_clear;
  logic              buf_load;
  logic              buf_hit;
  logic [7:0]        buf_byte;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] waddr_start;
  logic              sel;
  logic              upload_rise;
  logic              upload_fall;
  logic              rd_ok;
  logic              unused_addr_hi;

  assign waddr_start = ADDR_W'(BASE_WORD);
  assign waddr       = waddr_start + ioctl_addr[ADDR_W:1];
  assign sel         = ioctl_addr[0];
  assign upload_rise = ioctl_upload & ~upload_q;
  assign upload_fall = ~ioctl_upload & upload_q;
  // Reads outside a session or while stalled are host protocol errors; drop them.
  assign rd_ok       = ioctl_rd & ioctl_upload & ~wait_q & ~upload_rise;

  assign unused_addr_hi = ^(ioctl_addr >> (ADDR_W + 1));

  ioctl_word_buf #(
    .ADDR_W (ADDR_W)
  ) u_word_buf (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .clear      (buf_clear),
    .load       (buf_load),
    .load_word  (mem_dout),
    .load_tag   (mem_addr_q),
    .lookup_tag (waddr),
    .lookup_sel (sel),
    .hit        (buf_hit),
    .rd_byte    (buf_byte)
  );

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_sel_d   = pend_sel_q;
    drain_addr_d = drain_addr_q;
    drain_pend_d = drain_pend_q;
    drain_sel_d  = drain_sel_q;
    mem_rd_d     = mem_rd_q;
    mem_addr_d   = mem_addr_q;
    din_d        = din_q;
    wait_d       = wait_q;
    bytes_d      = bytes_q;
    serve        = 1'b0;
    buf_clear    = 1'b0;
    buf_load     = 1'b0;

    // Any acknowledge retires the outstanding request; branches below may
    // immediately issue a new one.
    if (mem_ack) mem_rd_d = 1'b0;

    if (upload_rise) begin
      buf_clear = 1'b1;
      bytes_d   = '0;
      pend_d    = 1'b0;
      wait_d    = 1'b0;
      if (mem_rd_q && !mem_ack) begin
        // A fetch orphaned by the previous session is still in flight; let it
        // finish before issuing the session's first prefetch.
        state_d      = StDrain;
        drain_addr_d = waddr_start;
        drain_pend_d = 1'b0;
        drain_sel_d  = 1'b0;
      end else begin
        mem_rd_d   = 1'b1;
        mem_addr_d = waddr_start;
        state_d    = StFetch;
      end
    end else if (upload_fall) begin
      // Outstanding fetch keeps mem_rd until its ack, which is then ignored.
      state_d   = StIdle;
      pend_d    = 1'b0;
      wait_d    = 1'b0;
      buf_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_ok) begin
            if (buf_hit) begin
              din_d = buf_byte;
              serve = 1'b1;
              if (sel) begin
                mem_rd_d   = 1'b1;
                mem_addr_d = waddr + ADDR_W'(1);
                state_d    = StFetch;
                pend_d     = 1'b0;
              end
            end else begin
              wait_d     = 1'b1;
              mem_rd_d   = 1'b1;
              mem_addr_d = waddr;
              state_d    = StFetch;
              pend_d     = 1'b1;
              pend_sel_d = sel;
            end
          end
        end

        StFetch: begin
          if (mem_ack) begin
            buf_load = 1'b1;
            state_d  = StIdle;
            if (pend_q) begin
              din_d  = select_byte(mem_dout, pend_sel_q);
              wait_d = 1'b0;
              serve  = 1'b1;
              pend_d = 1'b0;
            end else if (rd_ok) begin
              // Read lands on the ack cycle: serve it from the returning word
              // or treat it as a fresh miss.
              if (waddr == mem_addr_q) begin
                din_d = select_byte(mem_dout, sel);
                serve = 1'b1;
                if (sel) begin
                  mem_rd_d   = 1'b1;
                  mem_addr_d = waddr + ADDR_W'(1);
                  state_d    = StFetch;
                end
              end else begin
                wait_d     = 1'b1;
                mem_rd_d   = 1'b1;
                mem_addr_d = waddr;
                state_d    = StFetch;
                pend_d     = 1'b1;
                pend_sel_d = sel;
              end
            end
          end else if (rd_ok) begin
            wait_d = 1'b1;
            if (waddr == mem_addr_q) begin
              pend_d     = 1'b1;
              pend_sel_d = sel;
            end else begin
              state_d      = StDrain;
              drain_addr_d = waddr;
              drain_pend_d = 1'b1;
              drain_sel_d  = sel;
            end
          end
        end

        StDrain: begin
          if (mem_ack) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = drain_addr_q;
            state_d    = StFetch;
            pend_d     = drain_pend_q;
            pend_sel_d = drain_sel_q;
          end
        end

        default: state_d = StIdle;
      endcase
    end

    if (serve && (bytes_q != {IOCTL_ADDR_W{1'b1}})) bytes_d = bytes_q + IOCTL_ADDR_W'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= StIdle;
      upload_q     <= 1'b0;
      pend_q       <= 1'b0;
      pend_sel_q   <= 1'b0;
      drain_addr_q <= '0;
      drain_pend_q <= 1'b0;
      drain_sel_q  <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      din_q        <= '0;
      wait_q       <= 1'b0;
      bytes_q      <= '0;
    end else begin
      state_q      <= state_d;
      upload_q     <= ioctl_upload;
      pend_q       <= pend_d;
      pend_sel_q   <= pend_sel_d;
      drain_addr_q <= drain_addr_d;
      drain_pend_q <= drain_pend_d;
      drain_sel_q  <= drain_sel_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      din_q        <= din_d;
      wait_q       <= wait_d;
      bytes_q      <= bytes_d;
    end
  end

  assign ioctl_din    = din_q;
  assign ioctl_wait   = wait_q;
  assign mem_rd       = mem_rd_q;
  assign mem_addr     = mem_addr_q;
  assign bytes_served = bytes_q;

endmodule

// File: doc/ioctl_upload_reader.md
# ioctl_upload_reader

Serves the HPS upload direction of the ioctl channel: when the OSD saves memory contents, hps_io issues byte reads and this block fetches the bytes from SDRAM through the bocks_top memory arbiter. It is the read-side counterpart of the download path that writes ioctl bytes into SDRAM. It sits in clk_sys between hps_io and the SDRAM controller's secondary request port. It keeps a one-word buffer with next-word prefetch so sequential uploads rarely stall.

## Interface
Parameters:
- ADDR_W, 25: SDRAM word-address width (16-bit words).
- BASE_WORD, 0: word offset added to every upload address.

Ports:
- clk_sys  in  1  system clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  upload session active, from hps_io.
- ioctl_rd  in  1  one-cycle byte-read strobe, from hps_io.
- ioctl_addr  in  27  byte address of the read.
- ioctl_din  out  8  byte returned to hps_io.
- ioctl_wait  out  1  stall to hps_io; high while ioctl_din is not yet valid.
- mem_rd  out  1  read request; held high until mem_ack.
- mem_addr  out  ADDR_W  word address; stable while mem_rd is high.
- mem_ack  in  1  one-cycle acknowledge; mem_dout is valid in the same cycle.
- mem_dout  in  16  read word; the low byte is the even byte address.
- bytes_served  out  27  count of completed ioctl_rd reads in this session.

## Operation
- Word address: waddr = (BASE_WORD + ioctl_addr[ADDR_W:1]) mod 2^ADDR_W. Byte select is ioctl_addr[0]: 0 selects mem_dout[7:0], 1 selects mem_dout[15:8].
- Buffer holds buf_word[15:0], buf_tag[ADDR_W-1:0] and buf_valid.
- States:
  - IDLE: no memory request outstanding.
  - FETCH: mem_rd is high; waiting for mem_ack. A pend_rd flag records whether a host read is waiting on this fetch.
  - DRAIN: a fetch is in flight, but the host needs a different word.
- Rising edge of ioctl_upload:
  - Clear buf_valid and bytes_served.
  - Issue a prefetch of waddr(0) and go to FETCH.
- ioctl_rd hit (buf_valid and buf_tag == waddr, state IDLE):
  - Drive the selected byte on ioctl_din.
  - Increment bytes_served.
  - If ioctl_addr[0] = 1, prefetch waddr+1 (wraps at 2^ADDR_W) and go to FETCH.
- ioctl_rd miss in IDLE: set ioctl_wait, set mem_addr = waddr and mem_rd, go to FETCH with pend_rd = 1.
- ioctl_rd during FETCH:
  - If mem_addr == waddr: set ioctl_wait and pend_rd; stay in FETCH.
  - Otherwise: set ioctl_wait and go to DRAIN. On mem_ack, discard the data, issue waddr and go to FETCH with pend_rd = 1.
- mem_ack in FETCH:
  - Load the buffer and set buf_valid.
  - If pend_rd: drive the byte, clear ioctl_wait, increment bytes_served, clear pend_rd.
  - Then go to IDLE.
- mem_ack in IDLE is ignored. This covers a stale ack after reset.
- ioctl_rd while ioctl_wait is high is a protocol violation and is ignored.
- ioctl_rd while ioctl_upload is low is ignored.
- Falling edge of ioctl_upload mid-fetch:
  - The fetch runs to mem_ack, and its data is discarded.
  - ioctl_wait drops immediately.
  - Go to IDLE and clear buf_valid.
- bytes_served saturates at 2^27-1.

## Timing
- Reset values: ioctl_din = 0, ioctl_wait = 0, mem_rd = 0, mem_addr = 0, bytes_served = 0, buf_valid = 0, state = IDLE. Reset mid-fetch drops mem_rd in the next cycle.
- All outputs are registered.
- Hit: ioctl_rd in cycle N → ioctl_din valid in N+1; ioctl_wait stays 0.
- Miss: ioctl_rd in N → ioctl_wait = 1 and mem_rd = 1 from N+1. mem_ack in M → ioctl_din valid and ioctl_wait = 0 in M+1.
- Prefetch: issued in the cycle after an odd-byte hit; mem_rd is high from N+1.
- Minimum miss latency with a zero-wait controller (mem_ack in N+1): 2 cycles.

## Structure
- bocks_pkg holds:
  - upload_state_t enum (IDLE, FETCH, DRAIN);
  - the default SDRAM word-address width constant, shared with the download path.
- One sub-module, ioctl_word_buf: buffer register, tag, valid, tag compare and byte select. The FSM and counter stay in the top module.

## Test plan
- Upload start, memory words 0x2211 then 0x4433, reads at addresses 0,1,2,3 with 4-cycle ack latency → ioctl_din = 11,22,33,44; ioctl_wait only on address 0 if the host reads before the first prefetch completes; bytes_served = 4.
- Single read at address 0x1001 with BASE_WORD = 0x100 → mem_addr = 0x900; ioctl_din = high byte one cycle after mem_ack.
- Read at address 6 while the prefetch of word 1 is pending → DRAIN; word 1 acked and discarded; word 3 fetched; correct byte returned.
- Odd read at waddr 2^ADDR_W-1 → prefetch wraps to mem_addr 0.
- Reset asserted during FETCH, then a late mem_ack → all outputs 0, ack ignored, buf_valid = 0.
- ioctl_upload falls mid-fetch → ioctl_wait = 0 next cycle; ack consumed; state IDLE.
